// File: rtl/pwm_led_driver.sv
// pwm_led_driver: multi-channel PWM output stage for the LED ramp pipeline.
// Turns each channel's DUTY_W-bit duty value into an LED drive waveform.
// The period is 2^DUTY_W-1 slots, and each slot lasts PRESCALE clocks.
// Duty is double-buffered: it is captured into a shadow register only at
// start or at a period wrap.
// The block also emits a period_start marker and a tick strobe every
// TICK_PERIODS periods to pace the ramp machines.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous, active-high reset
//   enable       in   run PWM; low stops counters and forces outputs inactive
//   duty         in   NUM_CH*DUTY_W, channel i at [i*DUTY_W +: DUTY_W]
//   led          out  NUM_CH registered PWM drive (inverted if ACTIVE_LOW)
//   period_start out  one-clk pulse in first cycle of each period
//   tick         out  one-clk pulse every TICK_PERIODS periods
module pwm_led_driver #(
    parameter int NUM_CH       = 8,
    parameter int DUTY_W       = 5,
    parameter int PRESCALE     = 16,
    parameter int TICK_PERIODS = 4,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH*DUTY_W-1:0] duty,
    output logic [NUM_CH-1:0]        led,
    output logic                     period_start,
    output logic                     tick
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int PER_W  = (TICK_PERIODS > 1) ? $clog2(TICK_PERIODS) : 1;
    localparam int SLOT_W = DUTY_W;  // max slot 2^DUTY_W-2 always fits

    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(TICK_PERIODS - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'((1 << DUTY_W) - 2);
    localparam logic [NUM_CH-1:0] LED_OFF  = {NUM_CH{ACTIVE_LOW}};

    logic                           running_q, running_d;
    logic [PRE_W-1:0]               pre_q, pre_d;
    logic [SLOT_W-1:0]              slot_q, slot_d;
    logic [PER_W-1:0]               per_q, per_d;
    logic [NUM_CH-1:0][DUTY_W-1:0]  shadow_q, shadow_d;
    logic [NUM_CH-1:0]              led_q, led_d, act_d;
    logic                           ps_q, ps_d;
    logic                           tick_q, tick_d;

    // Counter next-state. Start, stop and run are mutually exclusive by running_q.
    always_comb begin
        running_d = running_q;
        pre_d     = pre_q;
        slot_d    = slot_q;
        per_d     = per_q;
        shadow_d  = shadow_q;
        if (!running_q) begin
            if (enable) begin
                running_d = 1'b1;
                pre_d     = '0;
                slot_d    = '0;
                per_d     = '0;
                shadow_d  = duty;
            end
        end else if (!enable) begin
            running_d = 1'b0;
            pre_d     = '0;
            slot_d    = '0;
            per_d     = '0;
        end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (slot_q == SLOT_MAX) begin
                // Period wrap: the only point mid-run where new duty is accepted.
                slot_d   = '0;
                shadow_d = duty;
                per_d    = (per_q == PER_MAX) ? '0 : per_q + 1'b1;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Outputs are derived from next-state so the registered pins line up
    // with the counters in the same cycle.
    always_comb begin
        ps_d   = running_d && (pre_d == '0) && (slot_d == '0);
        tick_d = ps_d && (per_d == PER_MAX);
    end

    // Per-channel compare. slot never reaches 2^DUTY_W-1, so full duty
    // stays on continuously across the period wrap.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign act_d[g] = running_d && (slot_d < shadow_d[g]);
    end

    assign led_d = act_d ^ LED_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            pre_q     <= '0;
            slot_q    <= '0;
            per_q     <= '0;
            shadow_q  <= '0;
            led_q     <= LED_OFF;
            ps_q      <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            running_q <= running_d;
            pre_q     <= pre_d;
            slot_q    <= slot_d;
            per_q     <= per_d;
            shadow_q  <= shadow_d;
            led_q     <= led_d;
            ps_q      <= ps_d;
            tick_q    <= tick_d;
        end
    end

    assign led          = led_q;
    assign period_start = ps_q;
    assign tick         = tick_q;

endmodule

// File: tb/tb_pwm_led_driver.sv
// Directed bench for pwm_led_driver with PRESCALE=2 and TICK_PERIODS=4,
// so one period is 62 clks.
// A second instance with ACTIVE_LOW=1 shares the stimulus.
module tb_pwm_led_driver;
    localparam int NC = 8;
    localparam int DW = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b1;
    logic [NC*DW-1:0] duty = '0;
    logic [NC-1:0]    led, led_n;
    logic             ps, tick, ps_n, tick_n;

    int n_chk = 0;
    int n_err = 0;

    pwm_led_driver #(.NUM_CH(NC), .DUTY_W(DW), .PRESCALE(2), .TICK_PERIODS(4), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .duty(duty),
        .led(led), .period_start(ps), .tick(tick));

    pwm_led_driver #(.NUM_CH(NC), .DUTY_W(DW), .PRESCALE(2), .TICK_PERIODS(4), .ACTIVE_LOW(1'b1)) u_dut_n (
        .clk(clk), .rst(rst), .enable(enable), .duty(duty),
        .led(led_n), .period_start(ps_n), .tick(tick_n));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input int ch, input logic [DW-1:0] v);
        duty[ch*DW +: DW] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int hi[4];
        int cont1, ps_cnt, tick_cnt, t1, t2, bad, badn, a, b, act, pcnt, tcnt;

        // Reset held with full duty and enable high.
        for (int ch = 0; ch < NC; ch++) set_duty(ch, 5'd31);
        step(3);
        chk("rst_led", led, 8'h00);
        chk("rst_ps", ps, 0);
        chk("rst_tick", tick, 0);
        chk("rst_led_n", led_n, 8'hFF);

        // Start with ch0=0, ch1=31, ch2=1, ch3=15.
        duty = '0;
        set_duty(1, 5'd31); set_duty(2, 5'd1); set_duty(3, 5'd15);
        rst = 1'b0;
        step(1);
        chk("start_ps", ps, 1);
        chk("start_tick", tick, 0);
        chk("start_led", led, 8'h0E);

        foreach (hi[i]) hi[i] = 0;
        cont1 = 0; ps_cnt = 0; tick_cnt = 0; t1 = -1; t2 = -1; bad = 0; badn = 0;
        for (int c = 0; c < 500; c++) begin
            if (c < 62) for (int ch = 0; ch < 4; ch++) hi[ch] += int'(led[ch]);
            cont1 += int'(led[1]);
            if (ps) ps_cnt++;
            if (tick) begin
                tick_cnt++;
                if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
                if (!ps) bad++;
            end
            if (led_n !== ~led) badn++;
            if (c < 499) step(1);
        end
        chk("hi_ch0", hi[0], 0);
        chk("hi_ch1", hi[1], 62);
        chk("hi_ch2", hi[2], 2);
        chk("hi_ch3", hi[3], 30);
        chk("ch1_continuous", cont1, 500);
        chk("ps_count", ps_cnt, 9);
        chk("tick_first", t1, 186);
        chk("tick_second", t2, 434);
        chk("tick_count", tick_cnt, 2);
        chk("tick_without_ps", bad, 0);
        chk("active_low_inv", badn, 0);

        // Restart with ch0=10, then raise it to 20 mid-period at slot 5.
        enable = 1'b0;
        step(1);
        chk("stop_led", led, 8'h00);
        chk("stop_ps", ps, 0);
        set_duty(0, 5'd10);
        enable = 1'b1;
        step(1);
        chk("restart_ps", ps, 1);
        a = 0; b = 0;
        for (int c = 0; c < 124; c++) begin
            if (led[0]) begin
                if (c < 62) a++; else b++;
            end
            if (c == 10) set_duty(0, 5'd20);
            if (c < 123) step(1);
        end
        chk("mid_cur_period", a, 20);
        chk("mid_next_period", b, 40);

        // Disable at slot 12, stay off for 10 clks, then re-enable.
        enable = 1'b0; step(1); enable = 1'b1; step(1);
        step(24);
        chk("slot12_led", led, 8'h0B);
        enable = 1'b0;
        step(1);
        chk("dis_led", led, 8'h00);
        chk("dis_ps", ps, 0);
        chk("dis_tick", tick, 0);
        chk("dis_led_n", led_n, 8'hFF);
        act = 0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (led != 0 || ps || tick) act++;
        end
        chk("dis_quiet", act, 0);
        enable = 1'b1;
        step(1);
        chk("reen_ps", ps, 1);
        chk("reen_led", led, 8'h0F);
        chk("reen_tick", tick, 0);
        t1 = -1; ps_cnt = 0;
        for (int c = 0; c < 227; c++) begin
            if (ps) ps_cnt++;
            if (tick && t1 < 0) t1 = c;
            if (c < 226) step(1);
        end
        chk("reen_tick_first", t1, 186);
        chk("reen_ps_count", ps_cnt, 4);
        chk("slot20_led", led, 8'h02);

        // Reset mid-run at slot 20, release with enable held high.
        rst = 1'b1;
        step(1);
        chk("midrst_led", led, 8'h00);
        chk("midrst_ps", ps, 0);
        chk("midrst_tick", tick, 0);
        chk("midrst_led_n", led_n, 8'hFF);
        rst = 1'b0;
        step(1);
        chk("post_rst_ps", ps, 1);
        chk("post_rst_led", led, 8'h0F);
        chk("post_rst_tick", tick, 0);
        step(1);
        chk("post_rst_ps_low", ps, 0);
        step(61);
        chk("post_rst_period2", ps, 1);
        chk("post_rst_tick2", tick, 0);

        // enable toggling every cycle: alternate start/stop.
        enable = 1'b0;
        step(1);
        pcnt = 0; tcnt = 0;
        for (int i = 0; i < 8; i++) begin
            enable = (i % 2 == 0);
            step(1);
            pcnt += int'(ps);
            tcnt += int'(tick);
        end
        chk("toggle_ps", pcnt, 4);
        chk("toggle_tick", tcnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
